// File: rtl/fuel_dispense_sequencer.sv
// Pump relay sequencer for one dispensing cycle: synchronizes and debounces the
// panel inputs, counts flow-meter pulses against a preset target and enforces interlocks.
module fuel_dispense_sequencer #(
  parameter int CLK_HZ       = 1_000_000,
  parameter int DEBOUNCE_CYC = 5000,
  parameter int PULSES_P0    = 350,
  parameter int PULSES_P1    = 800,
  parameter int PULSES_P2    = 1600,
  parameter int TIMEOUT_CYC  = 2_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn0,
  input  logic        btn1,
  input  logic        btn2,
  input  logic        btn_stop,
  input  logic        flow_pulse,
  input  logic        tank_low,
  output logic        relay_out,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [15:0] disp_count,
  output logic [15:0] target
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PUMP  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_TIMEOUT = 2'b01;
  localparam logic [1:0] CODE_TANK    = 2'b10;

  if (CLK_HZ < 1 || DEBOUNCE_CYC < 1 || TIMEOUT_CYC < 1 ||
      PULSES_P0 < 1 || PULSES_P0 > 65535 || PULSES_P1 < 1 || PULSES_P1 > 65535 ||
      PULSES_P2 < 1 || PULSES_P2 > 65535) begin : g_bad_params
    $error("fuel_dispense_sequencer: parameter out of range");
  end

  logic [5:0]            sync1_q, sync1_d, sync2_q, sync2_d;
  logic [3:0]            db_level_q, db_level_d, db_prev_q, db_prev_d;
  logic [3:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic                  flow_prev_q, flow_prev_d;
  logic [1:0]            state_q, state_d;
  logic [1:0]            fcode_q, fcode_d;
  logic [15:0]           disp_q, disp_d, target_q, target_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  relay_q, relay_d, busy_q, busy_d, done_q, done_d, fault_q, fault_d;

  logic [3:0]  req;
  logic        flow_edge;
  logic        tank_sync;
  logic [15:0] disp_inc;

  // Front end: bit order is {tank_low, flow_pulse, btn_stop, btn2, btn1, btn0}.
  always_comb begin
    sync1_d     = {tank_low, flow_pulse, btn_stop, btn2, btn1, btn0};
    sync2_d     = sync1_q;
    flow_prev_d = sync2_q[4];
    db_prev_d   = db_level_q;
    db_level_d  = db_level_q;
    db_cnt_d    = '0;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] != db_level_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
          db_level_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign req       = db_level_q & ~db_prev_q;
  assign flow_edge = sync2_q[4] & ~flow_prev_q;
  assign tank_sync = sync2_q[5];
  assign disp_inc  = (disp_q == 16'hFFFF) ? disp_q : disp_q + 16'd1;

  // Exit order from PUMP is completion, stop, tank low, then no-flow timeout.
  always_comb begin
    state_d  = state_q;
    fcode_d  = fcode_q;
    disp_d   = disp_q;
    target_d = target_q;
    to_cnt_d = to_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|req[2:0]) begin
          if (req[0])      target_d = 16'(PULSES_P0);
          else if (req[1]) target_d = 16'(PULSES_P1);
          else             target_d = 16'(PULSES_P2);
          disp_d   = '0;
          to_cnt_d = '0;
          if (tank_sync) begin
            state_d = ST_FAULT;
            fcode_d = CODE_TANK;
          end else begin
            state_d = ST_PUMP;
          end
        end
      end
      ST_PUMP: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (flow_edge) begin
          disp_d   = disp_inc;
          to_cnt_d = '0;
        end
        if (flow_edge && disp_inc == target_q) begin
          state_d = ST_DONE;
        end else if (req[3]) begin
          state_d = ST_IDLE;
        end else if (tank_sync) begin
          state_d = ST_FAULT;
          fcode_d = CODE_TANK;
        end else if (!flow_edge && to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          state_d = ST_FAULT;
          fcode_d = CODE_TIMEOUT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_FAULT: begin
        if (req[3]) begin
          state_d = ST_IDLE;
          fcode_d = CODE_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    relay_d = (state_d == ST_PUMP);
    busy_d  = (state_d == ST_PUMP);
    done_d  = (state_d == ST_DONE);
    fault_d = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      db_level_q  <= '0;
      db_prev_q   <= '0;
      db_cnt_q    <= '0;
      flow_prev_q <= 1'b0;
      state_q     <= ST_IDLE;
      fcode_q     <= CODE_NONE;
      disp_q      <= '0;
      target_q    <= '0;
      to_cnt_q    <= '0;
      relay_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_level_q  <= db_level_d;
      db_prev_q   <= db_prev_d;
      db_cnt_q    <= db_cnt_d;
      flow_prev_q <= flow_prev_d;
      state_q     <= state_d;
      fcode_q     <= fcode_d;
      disp_q      <= disp_d;
      target_q    <= target_d;
      to_cnt_q    <= to_cnt_d;
      relay_q     <= relay_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
    end
  end

  assign relay_out  = relay_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fault      = fault_q;
  assign fault_code = fcode_q;
  assign disp_count = disp_q;
  assign target     = target_q;

endmodule

// File: tb/tb_fuel_dispense_sequencer.sv
// Directed bench for fuel_dispense_sequencer with small debounce/timeout values
// so every scenario completes in a few hundred cycles.
module tb_fuel_dispense_sequencer;

  localparam int DB = 4;
  localparam int P0 = 5;
  localparam int P1 = 10;
  localparam int P2 = 20;
  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn0 = 1'b0, btn1 = 1'b0, btn2 = 1'b0, btn_stop = 1'b0;
  logic        flow_pulse = 1'b0, tank_low = 1'b0;
  logic        relay_out, busy, done, fault;
  logic [1:0]  fault_code;
  logic [15:0] disp_count, target;

  int cmp_count = 0;
  int err_count = 0;
  int done_seen = 0;
  int relay_cycles = 0;

  fuel_dispense_sequencer #(
    .CLK_HZ(1_000_000), .DEBOUNCE_CYC(DB), .PULSES_P0(P0), .PULSES_P1(P1),
    .PULSES_P2(P2), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn0(btn0), .btn1(btn1), .btn2(btn2),
    .btn_stop(btn_stop), .flow_pulse(flow_pulse), .tank_low(tank_low),
    .relay_out(relay_out), .busy(busy), .done(done), .fault(fault),
    .fault_code(fault_code), .disp_count(disp_count), .target(target)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_seen++;
    if (relay_out) relay_cycles++;
  end

  task automatic checkOutput(input string tag, input int unsigned observed, input int unsigned expected);
    cmp_count++;
    if (observed !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // buttons = {btn_stop, btn2, btn1, btn0}
  task automatic applyStimulus(input logic [3:0] buttons, input int hold);
    {btn_stop, btn2, btn1, btn0} = buttons;
    waitCycles(hold);
    {btn_stop, btn2, btn1, btn0} = 4'b0000;
  endtask

  task automatic flowPulse();
    flow_pulse = 1'b1;
    waitCycles(5);
    flow_pulse = 1'b0;
    waitCycles(5);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_relay"}, relay_out, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_fault"}, fault, 0);
    checkOutput({tag, "_code"}, fault_code, 0);
    checkOutput({tag, "_disp"}, disp_count, 0);
    checkOutput({tag, "_target"}, target, 0);
  endtask

  initial begin
    @(negedge clk);
    waitCycles(3);
    checkResetValues("rst");
    rst_n = 1'b1;
    waitCycles(2);

    // btn0 held 20 cycles: relay rises 7 cycles after press
    btn0 = 1'b1;
    waitCycles(6);
    checkOutput("t1_relay_pre", relay_out, 0);
    waitCycles(1);
    checkOutput("t1_relay_on", relay_out, 1);
    checkOutput("t1_busy", busy, 1);
    checkOutput("t1_target", target, P0);
    checkOutput("t1_disp0", disp_count, 0);
    waitCycles(13);
    btn0 = 1'b0;
    waitCycles(2);
    for (int i = 1; i <= 4; i++) begin
      flowPulse();
      checkOutput("t1_disp_step", disp_count, i);
    end
    flow_pulse = 1'b1;
    waitCycles(2);
    checkOutput("t1_relay_before5", relay_out, 1);
    checkOutput("t1_disp_before5", disp_count, 4);
    waitCycles(1);
    checkOutput("t1_relay_off5", relay_out, 0);
    checkOutput("t1_disp5", disp_count, 5);
    checkOutput("t1_done_hi", done, 1);
    waitCycles(1);
    checkOutput("t1_done_lo", done, 0);
    waitCycles(1);
    flow_pulse = 1'b0;
    waitCycles(5);
    checkOutput("t1_done_count", done_seen, 1);
    checkOutput("t1_busy_end", busy, 0);

    // btn1 glitch ignored; simultaneous btn1+btn2 takes btn1
    applyStimulus(4'b0010, 3);
    waitCycles(10);
    checkOutput("t2_glitch_busy", busy, 0);
    checkOutput("t2_glitch_target", target, P0);
    btn1 = 1'b1;
    btn2 = 1'b1;
    waitCycles(7);
    checkOutput("t2_busy", busy, 1);
    checkOutput("t2_target", target, P1);
    waitCycles(3);
    btn1 = 1'b0;
    btn2 = 1'b0;
    waitCycles(10);
    applyStimulus(4'b1000, 7);
    checkOutput("t2_stop_busy", busy, 0);
    checkOutput("t2_stop_disp", disp_count, 0);
    checkOutput("t2_done_count", done_seen, 1);
    waitCycles(10);

    // btn2, 7 pulses, then no-flow timeout
    applyStimulus(4'b0100, 10);
    checkOutput("t3_target", target, P2);
    waitCycles(2);
    for (int i = 0; i < 7; i++) flowPulse();
    waitCycles(92);
    checkOutput("t3_fault_pre", fault, 0);
    checkOutput("t3_busy_pre", busy, 1);
    waitCycles(1);
    checkOutput("t3_fault", fault, 1);
    checkOutput("t3_code", fault_code, 1);
    checkOutput("t3_relay", relay_out, 0);
    checkOutput("t3_disp", disp_count, 7);
    applyStimulus(4'b1000, 7);
    checkOutput("t3_clear_fault", fault, 0);
    checkOutput("t3_clear_code", fault_code, 0);
    checkOutput("t3_hold_disp", disp_count, 7);
    waitCycles(10);

    // tank low before request: fault 10, relay never on
    tank_low = 1'b1;
    waitCycles(4);
    relay_cycles = 0;
    applyStimulus(4'b0001, 7);
    checkOutput("t4_fault", fault, 1);
    checkOutput("t4_code", fault_code, 2);
    checkOutput("t4_target", target, P0);
    waitCycles(10);
    checkOutput("t4_relay_never", relay_cycles, 0);
    tank_low = 1'b0;
    waitCycles(3);
    applyStimulus(4'b1000, 7);
    checkOutput("t4_clear", fault, 0);
    waitCycles(10);

    // tank low mid-pump
    applyStimulus(4'b0001, 10);
    waitCycles(2);
    flowPulse();
    flowPulse();
    tank_low = 1'b1;
    waitCycles(2);
    checkOutput("t5_relay_pre", relay_out, 1);
    waitCycles(1);
    checkOutput("t5_relay", relay_out, 0);
    checkOutput("t5_fault", fault, 1);
    checkOutput("t5_code", fault_code, 2);
    checkOutput("t5_disp", disp_count, 2);
    tank_low = 1'b0;
    waitCycles(3);
    applyStimulus(4'b1000, 7);
    checkOutput("t5_clear", fault, 0);
    waitCycles(10);

    // stop after 3 pulses
    applyStimulus(4'b0001, 10);
    waitCycles(2);
    for (int i = 0; i < 3; i++) flowPulse();
    applyStimulus(4'b1000, 7);
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_fault", fault, 0);
    checkOutput("t6_disp", disp_count, 3);
    checkOutput("t6_done_count", done_seen, 1);
    waitCycles(10);

    // stop request and 5th pulse in the same cycle: completion wins
    applyStimulus(4'b0001, 10);
    waitCycles(2);
    for (int i = 0; i < 4; i++) flowPulse();
    checkOutput("t7_disp4", disp_count, 4);
    btn_stop = 1'b1;
    waitCycles(4);
    flow_pulse = 1'b1;
    waitCycles(3);
    checkOutput("t7_done", done, 1);
    checkOutput("t7_relay", relay_out, 0);
    checkOutput("t7_disp", disp_count, 5);
    waitCycles(1);
    checkOutput("t7_done_lo", done, 0);
    checkOutput("t7_busy", busy, 0);
    checkOutput("t7_fault", fault, 0);
    waitCycles(1);
    flow_pulse = 1'b0;
    btn_stop = 1'b0;
    waitCycles(10);
    checkOutput("t7_done_count", done_seen, 2);

    // flow pulses in idle are not counted
    for (int i = 0; i < 3; i++) flowPulse();
    checkOutput("t9_idle_disp", disp_count, 5);
    checkOutput("t9_idle_busy", busy, 0);

    // synchronous reset mid-pump
    applyStimulus(4'b0001, 10);
    waitCycles(2);
    flowPulse();
    flowPulse();
    checkOutput("t8_relay_pre", relay_out, 1);
    checkOutput("t8_disp_pre", disp_count, 2);
    rst_n = 1'b0;
    waitCycles(1);
    checkResetValues("t8");
    rst_n = 1'b1;
    waitCycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule

// File: doc/fuel_dispense_sequencer.md
# fuel_dispense_sequencer

Sequences the single pump relay for one dispensing cycle. It accepts preset-volume requests from three front-panel buttons and a stop button. Dispensed volume is measured by counting flow-meter pulses rather than by elapsed time. The block enforces tank-level and no-flow interlocks, and it sits between the raw panel/sensor inputs and the relay driver.

## Interface
- CLK_HZ, 1_000_000: system clock frequency, informational only
- DEBOUNCE_CYC, 5000: number of consecutive stable synchronized cycles needed to change a debounced button level
- PULSES_P0, 350: flow-pulse target for btn0 preset
- PULSES_P1, 800: flow-pulse target for btn1 preset
- PULSES_P2, 1600: flow-pulse target for btn2 preset
- TIMEOUT_CYC, 2_000_000: maximum cycles between flow pulses while pumping
- All targets are in the range 1..65535.

- clk  in  1  system clock, single clock domain
- rst_n  in  1  synchronous reset, active-low
- btn0, btn1, btn2  in  1 each  raw preset buttons, active-high, asynchronous
- btn_stop  in  1  raw stop/clear button, active-high, asynchronous
- flow_pulse  in  1  raw flow-meter output, asynchronous; one rising edge equals one unit
- tank_low  in  1  level sensor, active-high meaning insufficient fuel, asynchronous
- relay_out  out  1  pump relay drive, active-high
- busy  out  1  high while in PUMP
- done  out  1  one-cycle pulse on successful completion
- fault  out  1  high while in FAULT
- fault_code  out  2  00 none, 01 no-flow timeout, 10 tank low
- disp_count  out  16  flow pulses counted in the current or last cycle
- target  out  16  latched target of the current or last cycle

## Operation
- All six raw inputs pass through a 2-FF synchronizer.
- The four buttons are then debounced. Each has its own counter, and the debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYC consecutive cycles.
- A request is a rising edge of a debounced level. A held button produces exactly one request.
- flow_pulse edge detection: a synchronized 0→1 transition is one pulse. There is no debounce on this input.
- States are IDLE, PUMP, DONE and FAULT. Reset enters IDLE.
- IDLE:
  - If a preset request arrives, latch target from the preset. Priority is btn0 > btn1 > btn2 when requests are simultaneous.
  - Clear disp_count and the timeout counter.
  - If synchronized tank_low = 1, go to FAULT with code 10 and keep the relay off. Otherwise go to PUMP.
  - A stop request in IDLE has no effect.
- PUMP:
  - relay_out = 1.
  - Each flow pulse increments disp_count and clears the timeout counter.
  - Preset requests are ignored.
- PUMP exits, in priority order:
  - (a) The pulse that makes disp_count == target moves to DONE.
  - (b) A stop request moves to IDLE with no done pulse.
  - (c) tank_low = 1 moves to FAULT with code 10.
  - (d) The timeout counter reaching TIMEOUT_CYC moves to FAULT with code 01.
- DONE: done = 1 for exactly one cycle, then IDLE.
- FAULT:
  - relay_out = 0 and fault = 1.
  - Only a stop request exits, to IDLE. This clears fault_code.
  - Preset requests are ignored.
- Flow pulses outside PUMP are not counted.
- disp_count and target hold their values after DONE, abort or FAULT until the next accepted request.
- disp_count saturates at 65535. It cannot exceed target in normal operation.

## Timing
- Reset values: relay_out 0, busy 0, done 0, fault 0, fault_code 00, disp_count 0, target 0.
- All debouncer and synchronizer state is also cleared by reset.
- Button to relay: a raw press stable from cycle 0 gives a debounced rise at cycle 2+DEBOUNCE_CYC. relay_out and busy rise on the following edge.
- Relay off on completion: relay_out falls on the same edge on which disp_count reaches target. done is high during the next cycle.
- Stop and fault: relay_out falls on the edge of the state transition.
- Synchronous reset mid-PUMP: relay_out is 0 after the first clock edge with rst_n = 0.
- Simultaneous events are resolved by the exit priority list above. Completion beats stop, tank_low and timeout on the same cycle.
- All outputs are registered.

## Test plan
Bench parameters: DEBOUNCE_CYC=4, PULSES_P0/P1/P2=5/10/20, TIMEOUT_CYC=100, flow pulse period 10 cycles.

- btn0 held 20 cycles, then 5 flow pulses:
  - relay_out rises 7 cycles after the press.
  - disp_count steps 1..5 and the relay drops on the 5th pulse.
  - done is high for exactly 1 cycle, target=5.
- A btn1 glitch of 3 cycles produces no request. btn1 and btn2 pressed in the same cycle latch target=10.
- btn2 with pulses stopping after 7:
  - FAULT with fault_code=01 is reached 100 cycles after the 7th pulse. relay_out=0 and disp_count=7.
  - btn_stop then returns to IDLE with fault=0.
- tank_low=1, then btn0: FAULT with code 10, and relay_out never asserts.
- tank_low rising mid-PUMP: relay drops and code=10.
- Stop at pulse 3 of btn0 gives IDLE with no done and disp_count=3.
- A stop and the 5th pulse in the same cycle give done=1.
- rst_n=0 mid-PUMP: relay_out=0 after 1 edge and all outputs are at their reset values.
- Flow pulses in IDLE leave disp_count unchanged.
